// File: rtl/drum_step_sequencer.sv
// Drum step sequencer: free-running audio-rate sample strobe plus a 16-step
// pattern player that issues one-cycle retrigger pulses to the sample
// address counters of every voice sharing this pattern lane.
//
// Output strobe semantics: there is no handshake. `en` is a one-cycle
// strobe every SAMPLE_DIV cycles, and `go` is a one-cycle pulse that is
// only ever high together with `en`. Downstream counters must sample both
// on the same clock edge and must not assume any back-pressure.
module drum_step_sequencer #(
    parameter int          SAMPLE_DIV   = 1042,
    parameter logic [15:0] STEP_SAMPLES = 16'd6000,
    parameter logic [15:0] PATTERN_INIT = 16'h8888
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        pattern_we,
    input  logic [15:0] pattern_in,
    input  logic        len_we,
    input  logic [15:0] len_in,
    output logic        en,
    output logic        go,
    output logic [3:0]  step,
    output logic        playing
);

    localparam int                DIV_W    = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    logic [DIV_W-1:0] div;
    logic [15:0]      scnt;
    logic [15:0]      step_len;
    logic [15:0]      pattern;
    logic [0:0]       state;

    // Sample-rate divider; runs in every state so voice tails keep playing.
    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
            en  <= 1'b0;
        end else begin
            en <= (div == DIV_LAST);
            if (div == DIV_LAST) begin
                div <= '0;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    // Pattern and step-length registers; a zero length is clamped to one.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern  <= PATTERN_INIT;
            step_len <= STEP_SAMPLES;
        end else begin
            if (pattern_we) begin
                pattern <= pattern_in;
            end
            if (len_we) begin
                step_len <= (len_in == 16'd0) ? 16'd1 : len_in;
            end
        end
    end

    // Play/idle state machine with step and in-step sample counting.
    // The >= compare lets a shortened step end on the next strobe instead
    // of running scnt all the way around 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            step  <= 4'd0;
            scnt  <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    step <= 4'd0;
                    scnt <= 16'd0;
                    if (run) begin
                        state <= ST_PLAY;
                    end
                end
                default: begin
                    if (!run) begin
                        state <= ST_IDLE;
                        step  <= 4'd0;
                        scnt  <= 16'd0;
                    end else if (en) begin
                        if (scnt >= (step_len - 16'd1)) begin
                            scnt <= 16'd0;
                            step <= step + 4'd1;
                        end else begin
                            scnt <= scnt + 16'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Retrigger decision: first sample of an active step, only on a strobe,
    // suppressed when run drops or reset is asserted in the same cycle.
    always_comb begin
        go = 1'b0;
        if (!reset && (state == ST_PLAY) && run && en && (scnt == 16'd0)) begin
            go = pattern[step];
        end
    end

    assign playing = (state == ST_PLAY);

endmodule

// File: doc/drum_step_sequencer.md
Name: drum_step_sequencer

Overview:
- Upstream trigger source for the kick/sample address counters.
- Generates the audio-rate sample strobe `en` and one-cycle `go` retrigger pulses from a 16-step pattern at a programmable step length.
- Each downstream sample counter consumes `en`, counting one address per strobe, and `go`, which restarts it from address 0.
- One instance drives all voice counters that share a pattern lane.

Parameters:
- SAMPLE_DIV, 1042, clk cycles per audio sample (50 MHz / 48 kHz); must be >= 2.
- STEP_SAMPLES, 16'd6000, reset value of step length in samples (120 BPM sixteenth notes at 48 kHz).
- PATTERN_INIT, 16'h8888, reset pattern; bit n = step n active.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- run  input  1  level; 1 = play pattern, 0 = stop
- pattern_we  input  1  load strobe for pattern_in
- pattern_in  input  16  new pattern, bit n = step n
- len_we  input  1  load strobe for len_in
- len_in  input  16  new step length in samples
- en  output  1  sample strobe, high 1 cycle every SAMPLE_DIV cycles
- go  output  1  trigger pulse, high 1 cycle, only coincident with en
- step  output  4  current step index
- playing  output  1  high while in PLAY

Behaviour:
- Reset (sync, checked on posedge clk, overrides everything):
  - en=0, go=0, step=0, playing=0.
  - Divider div=0, sample count scnt=0.
  - pattern=PATTERN_INIT, step_len=STEP_SAMPLES, state=IDLE.
- Divider:
  - div counts 0..SAMPLE_DIV-1 and wraps.
  - en is registered: high in the cycle after div==SAMPLE_DIV-1, i.e. first en at cycle SAMPLE_DIV after reset release.
  - Divider free-runs in both states, so downstream counters keep playing out tails after stop.
- States:
  - IDLE: playing=0, go=0, step=0, scnt=0. If run=1, go to PLAY next cycle.
  - PLAY: playing=1. If run=0, go to IDLE next cycle; step/scnt cleared; no go issued in the exit cycle.
- PLAY sequencing, evaluated on each en cycle:
  - If scnt==0: go = pattern[step].
  - If scnt >= step_len-1: scnt -> 0 and step -> step+1 (15 wraps to 0). Otherwise scnt -> scnt+1.
  - Non-en cycles hold scnt and step. go is never high without en.
- First step after entering PLAY: step 0, scnt 0, so the first en in PLAY fires go if pattern[0]=1.
- Pattern load:
  - pattern_we registers pattern_in, visible the following cycle.
  - A go decision in the same cycle as pattern_we uses the old pattern.
- Step length load:
  - len_we registers len_in immediately; len_in==0 is stored as 1.
  - Because the compare is >=, shrinking below the current scnt ends the step on the next en. No lockup, no 65536-sample wrap.
  - step_len=1 fires the step boundary every en; go may then be high on consecutive en strobes.
- Simultaneous events:
  - reset beats all.
  - run falling beats an en in the same cycle: no go, step cleared.
  - pattern_we and len_we together both take effect.
- Width rules: scnt and step_len are 16-bit unsigned; step is 4-bit modulo 16.
- Reset mid-PLAY: state IDLE next cycle, go low. The downstream counter is not retriggered, so it completes its current sample.

Test Plan (bench params SAMPLE_DIV=4, STEP_SAMPLES=3, PATTERN_INIT=16'h0001):
- Reset, release, hold run=0 for 20 cycles -> en high at cycles 4,8,12,16,20 only; go=0, step=0, playing=0 throughout.
- run=1 -> playing=1 next cycle; go high on first en; step advances to 1 after 3 en; step 15 wraps to 0 after 48 en; go again only at step 0 (every 48 en).
- Load pattern_in=16'hFFFF mid-step 2 -> go high at scnt==0 of steps 3,4,...; drive pattern_we in the same cycle as a go decision -> that decision uses the old pattern.
- At scnt==2 with step_len=5, set len_in=2 -> step advances on the next en; len_in=0 -> step advances every en, go on every en with pattern 16'hFFFF.
- Drop run in a cycle coincident with en at scnt==0, pattern bit 1 -> go stays 0, step=0, playing=0 next cycle, en continues.
- Assert reset mid-PLAY at step 7 -> next cycle step=0, go=0, playing=0, pattern back to 16'h0001, step_len back to 3.
